ex_stage: RTL

- Execute stage of the 5-stage pipeline; sits directly upstream of the memory stage and drives its inputs.
- Computes the ALU result, the Zero flag and the branch target, and registers them into the EX/MEM latch.
- Adds an iterative 32-cycle shift-add multiplier. It stalls the upstream stages while busy, and a flush from the branch decision squashes it.

---
 rtl/ex_stage.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// Execute stage: ALU, Zero flag, branch target and EX/MEM latch, plus an
// iterative shift-add multiplier that stalls upstream while it runs.
module ex_stage #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] PC_plus4,
  input  logic [WIDTH-1:0] ReadData1,
  input  logic [WIDTH-1:0] ReadData2,
  input  logic [WIDTH-1:0] SignExtImm,
  input  logic [4:0]       Rt,
  input  logic [4:0]       Rd,
  input  logic             RegDst,
  input  logic             ALUSrc,
  input  logic [3:0]       ALUControl,
  input  logic [1:0]       WBControl,
  input  logic             MemWrite,
  input  logic             MemRead,
  input  logic             Branch,
  input  logic             flush,
  output logic             stall,
  output logic             out_valid,
  output logic [WIDTH-1:0] ALUResult_out,
  output logic [WIDTH-1:0] WriteData_out,
  output logic [4:0]       WriteReg_out,
  output logic [1:0]       WBControl_out,
  output logic             MemWrite_out,
  output logic             MemRead_out,
  output logic             Branch_out,
  output logic             Zero_out,
  output logic [WIDTH-1:0] BranchTarget_out
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1000;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam int         CNT_W   = $clog2(MUL_CYCLES + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} mul_state_t;

  mul_state_t       state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] count;

  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] cap_result;
  logic             is_mul;
  logic             start_mul;
  logic             cap_en;

  always_comb begin
    op_b = ALUSrc ? SignExtImm : ReadData2;
    case (ALUControl)
      ALU_AND: alu_result = ReadData1 & op_b;
      ALU_OR:  alu_result = ReadData1 | op_b;
      ALU_ADD: alu_result = ReadData1 + op_b;
      ALU_SUB: alu_result = ReadData1 - op_b;
      ALU_NOR: alu_result = ~(ReadData1 | op_b);
      ALU_SLT: alu_result = {{(WIDTH-1){1'b0}}, $signed(ReadData1) < $signed(op_b)};
      default: alu_result = '0;
    endcase
  end

  assign is_mul     = (ALUControl == ALU_MUL);
  assign start_mul  = in_valid && is_mul && !flush && (state == IDLE);
  // Stall is held low during reset so upstream never freezes on a stale state.
  assign stall      = rst_n && (start_mul || ((state == BUSY) && !flush));
  assign cap_en     = in_valid && !flush &&
                      (((state == IDLE) && !is_mul) || (state == DONE));
  assign cap_result = (state == DONE) ? acc : alu_result;

  // EX/MEM latch: every cycle not capturing an instruction captures a zeroed bubble.
  always_ff @(posedge clk) begin
    if (!rst_n || !cap_en) begin
      out_valid        <= 1'b0;
      ALUResult_out    <= '0;
      WriteData_out    <= '0;
      WriteReg_out     <= '0;
      WBControl_out    <= '0;
      MemWrite_out     <= 1'b0;
      MemRead_out      <= 1'b0;
      Branch_out       <= 1'b0;
      Zero_out         <= 1'b0;
      BranchTarget_out <= '0;
    end else begin
      out_valid        <= 1'b1;
      ALUResult_out    <= cap_result;
      WriteData_out    <= ReadData2;
      WriteReg_out     <= RegDst ? Rd : Rt;
      WBControl_out    <= WBControl;
      MemWrite_out     <= MemWrite;
      MemRead_out      <= MemRead;
      Branch_out       <= Branch;
      Zero_out         <= (cap_result == '0);
      BranchTarget_out <= PC_plus4 + (SignExtImm << 2);
    end
  end

  // Multiplier FSM: IDLE latches operands, BUSY runs one shift-add per edge,
  // DONE presents the product for one cycle while EX/MEM captures it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start_mul) begin
            mcand  <= ReadData1;
            mplier <= op_b;
            acc    <= '0;
            count  <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CNT_W'(1);
          if (count == CNT_W'(MUL_CYCLES - 1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
